// File: rtl/weight_stream_loader.sv
// Unpacks 32-bit stream words into two 16-bit weights and writes them one
// per cycle into the local weight memory, starting at a programmed base.
module weight_stream_loader #(
  parameter int MAX_WEIGHT_NUM = 2000,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] weight_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              write_weight_signal,
  output logic [ADDR_W-1:0] write_weight_addr,
  output logic [15:0]       write_weight_data,
  output logic              busy,
  output logic              done,
  output logic              addr_err
);

  // One extra bit so a depth of exactly 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   L_MAX  = (ADDR_W+1)'(MAX_WEIGHT_NUM);
  localparam logic [ADDR_W-1:0] L_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] L_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic              r_addr_err;

  logic w_in_range;
  logic w_more;
  logic w_wr_state;

  assign w_in_range = ({1'b0, r_addr} < L_MAX);
  assign w_more     = (r_rem > L_ONE);
  assign w_wr_state = (r_state == S_WR_LO) || (r_state == S_WR_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (weight_count != L_ZERO) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          w_state_next = S_WR_LO;
        end
      end
      S_WR_LO: w_state_next = w_more ? S_WR_HI : S_DONE;
      S_WR_HI: w_state_next = w_more ? S_FETCH : S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Address and count advance even on suppressed writes so the load always ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_addr     <= '0;
      r_rem      <= '0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_rem      <= weight_count;
            r_addr_err <= 1'b0;
          end
        end
        S_FETCH: begin
          if (in_valid) begin
            r_word <= in_data;
          end
        end
        S_WR_LO, S_WR_HI: begin
          r_addr <= r_addr + L_ONE;
          r_rem  <= r_rem - L_ONE;
          if (!w_in_range) begin
            r_addr_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    in_ready            = 1'b0;
    write_weight_signal = 1'b0;
    write_weight_addr   = '0;
    write_weight_data   = '0;
    busy                = (r_state != S_IDLE);
    done                = (r_state == S_DONE);
    addr_err            = r_addr_err;
    if (r_state == S_FETCH) begin
      in_ready = 1'b1;
    end
    if (w_wr_state && w_in_range) begin
      write_weight_signal = 1'b1;
      write_weight_addr   = r_addr;
      write_weight_data   = (r_state == S_WR_LO) ? r_word[15:0] : r_word[31:16];
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Bench for weight_stream_loader: directed and randomized loads compared with
// a transaction-level model of the expected write list and cycle timing.
module tb_weight_stream_loader;
  localparam int MAXW = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] weight_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        write_weight_signal;
  logic [15:0] write_weight_addr;
  logic [15:0] write_weight_data;
  logic        busy;
  logic        done;
  logic        addr_err;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] words[$];

  always #5 clk = ~clk;

  weight_stream_loader #(.MAX_WEIGHT_NUM(MAXW), .ADDR_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_addr           (base_addr),
    .weight_count        (weight_count),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_data             (in_data),
    .write_weight_signal (write_weight_signal),
    .write_weight_addr   (write_weight_addr),
    .write_weight_data   (write_weight_data),
    .busy                (busy),
    .done                (done),
    .addr_err            (addr_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: in_valid always high; 1: random valid; 2: valid low for the first 5 FETCH cycles.
  // poke: extra start pulses while busy and during the done cycle.
  task automatic run_load(input logic [15:0] base, input logic [15:0] cnt,
                          input int mode, input bit poke);
    int nwords = (int'(cnt) + 1) / 2;
    int stall  = (mode == 2) ? 5 : 0;
    int bound  = 4 * int'(cnt) + 60;
    logic [31:0] w[$];
    int exp_a[$], exp_d[$], exp_c[$];
    int act_a[$], act_d[$], act_c[$];
    bit exp_err = 1'b0;
    logic [15:0] a;
    logic [15:0] d;
    int n = 0, widx = 0, hs = 0, done_n = -1, done_cnt = 0;
    int ready_seen = 0, busy_low = 0, dirty = 0;
    bit prev_ready = 1'b0;

    for (int k = 0; k < nwords; k++) begin
      if (words.size() > 0) w.push_back(words.pop_front());
      else w.push_back($urandom);
    end
    words.delete();

    // Reference: weight i goes to base+i (mod 2^16); word i/2 supplies it, low half first.
    for (int i = 0; i < int'(cnt); i++) begin
      a = base + 16'(i);
      d = (i % 2 == 0) ? w[i/2][15:0] : w[i/2][31:16];
      if (int'(a) < MAXW) begin
        exp_a.push_back(int'(a));
        exp_d.push_back(int'(d));
        exp_c.push_back(i + i / 2 + 2 + stall);
      end else begin
        exp_err = 1'b1;
      end
    end

    base_addr    = base;
    weight_count = cnt;
    start        = 1'b1;
    in_valid     = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data      = (w.size() > 0) ? w[0] : $urandom;

    while (n < bound) begin
      @(posedge clk);
      #1;
      n++;
      if (prev_ready && in_valid) begin
        hs++;
        widx++;
      end
      start        = 1'b0;
      base_addr    = 16'($urandom);
      weight_count = 16'($urandom_range(1, 9));
      if (poke && n == 3) start = 1'b1;
      prev_ready = in_ready;
      if (in_ready) ready_seen++;
      if (!busy) busy_low++;
      if (n == 1) chk("err_clear_on_start", addr_err, 0);
      if (write_weight_signal) begin
        act_a.push_back(int'(write_weight_addr));
        act_d.push_back(int'(write_weight_data));
        act_c.push_back(n);
      end else if (write_weight_addr != 0 || write_weight_data != 0) begin
        dirty++;
      end
      if (done) begin
        done_cnt++;
        done_n = n;
        if (poke) start = 1'b1;
        break;
      end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ($urandom_range(0, 2) != 0);
        default: in_valid = (n >= 6);
      endcase
      in_data = (widx < w.size()) ? w[widx] : $urandom;
    end

    chk("done_pulses", done_cnt, 1);
    if (mode != 1) chk("done_cycle", done_n, int'(cnt) + nwords + 1 + stall);
    chk("handshakes", hs, nwords);
    chk("write_count", act_a.size(), exp_a.size());
    for (int k = 0; k < act_a.size() && k < exp_a.size(); k++) begin
      chk("write_addr", act_a[k], exp_a[k]);
      chk("write_data", act_d[k], exp_d[k]);
      if (mode != 1) chk("write_cycle", act_c[k], exp_c[k]);
    end
    chk("idle_write_bus_zero", dirty, 0);
    chk("busy_during_load", busy_low, 0);
    if (cnt == 0) chk("ready_on_zero_count", ready_seen, 0);

    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("post_done_idle", {busy, done, in_ready, write_weight_signal}, 0);
    chk("addr_err_sticky", addr_err, exp_err);
    $display("load base=%0d count=%0d mode=%0d poke=%0d writes=%0d words=%0d done_at=%0d",
             base, cnt, mode, poke, act_a.size(), hs, done_n);
  endtask

  initial begin
    logic [31:0] rw;
    int sel;
    logic [15:0] rb;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    base_addr = '0; weight_count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {in_ready, write_weight_signal, write_weight_addr, write_weight_data, busy, done, addr_err}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    words = '{32'h0002_0001, 32'h0004_0003};
    run_load(16'd0, 16'd4, 0, 1'b0);
    words = '{32'hBBBB_AAAA, 32'hDDDD_CCCC};
    run_load(16'd100, 16'd3, 0, 1'b0);
    run_load(16'd50, 16'd6, 2, 1'b0);
    run_load(16'd1998, 16'd4, 0, 1'b0);
    run_load(16'd10, 16'd2, 0, 1'b0);
    run_load(16'd5, 16'd0, 0, 1'b0);
    run_load(16'd200, 16'd4, 0, 1'b1);
    run_load(16'hFFFE, 16'd4, 0, 1'b0);

    // Reset in the middle of a 6-weight load, during WR_HI of the first word.
    rw = $urandom;
    base_addr = 16'd300; weight_count = 16'd6; start = 1'b1;
    in_valid = 1'b1; in_data = rw;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_wr_hi", {write_weight_signal, write_weight_addr, write_weight_data},
        {1'b1, 16'd301, rw[31:16]});
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs",
        {in_ready, write_weight_signal, write_weight_addr, write_weight_data, busy, done, addr_err}, 0);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_in_reset", {done, busy}, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("no_done_after_reset", {done, busy}, 0);
    run_load(16'd700, 16'd5, 0, 1'b0);

    for (int t = 0; t < 14; t++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rb = 16'($urandom_range(0, 50));
        1:       rb = 16'($urandom_range(1990, 2005));
        2:       rb = 16'($urandom_range(0, 65535));
        default: rb = 16'($urandom_range(65530, 65535));
      endcase
      run_load(rb, 16'($urandom_range(0, 9)), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
